// File: rtl/led_sequencer_multi.sv
// Single-lit-LED sequencer: sweeps a one-hot position across LED_OUT with a
// per-position dwell, in single-sweep, continuous-loop or bounce mode.
module led_sequencer_multi #(
   parameter int unsigned LED_WIDTH  = 8,
   parameter int unsigned STEP_TICKS = 50000000,
   parameter int unsigned CNT_WIDTH  = 26,
   parameter int unsigned IDX_WIDTH  = 3
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [1:0]           MASTER_CONTROL,
   input  logic                 START,
   input  logic                 PAUSE,
   output logic [LED_WIDTH-1:0] LED_OUT,
   output logic [IDX_WIDTH-1:0] POS_OUT,
   output logic [1:0]           STATE_OUT,
   output logic                 SWEEP_DONE
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   localparam logic [1:0]           MODE_STOP   = 2'd0;
   localparam logic [1:0]           MODE_SINGLE = 2'd1;
   localparam logic [1:0]           MODE_LOOP   = 2'd2;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT    = CNT_WIDTH'(STEP_TICKS - 1);
   localparam logic [IDX_WIDTH-1:0] LAST_POS    = IDX_WIDTH'(LED_WIDTH - 1);
   localparam logic [IDX_WIDTH-1:0] TURN_POS    = IDX_WIDTH'(LED_WIDTH - 2);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [IDX_WIDTH-1:0]   pos_q, pos_d;
   logic [1:0]             mode_q, mode_d;
   logic [LED_WIDTH-1:0]   led_d;
   logic                   done_d;

   // State register; LED and done pulse are registered alongside it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         pos_q      <= '0;
         mode_q     <= MODE_STOP;
         LED_OUT    <= '0;
         SWEEP_DONE <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pos_q      <= pos_d;
         mode_q     <= mode_d;
         LED_OUT    <= led_d;
         SWEEP_DONE <= done_d;
      end
   end

   // Next-state: abort beats pause, pause beats dwell advance.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pos_d   = pos_q;
      mode_d  = mode_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            pos_d   = '0;
            if (START && (MASTER_CONTROL != MODE_STOP)) begin
               state_d = ST_UP;
               mode_d  = MASTER_CONTROL;
            end
         end
         ST_UP, ST_DOWN: begin
            if (MASTER_CONTROL == MODE_STOP) begin
               state_d = ST_IDLE;
               count_d = '0;
               pos_d   = '0;
            end else if (PAUSE) begin
               count_d = count_q;
            end else if (count_q != LAST_CNT) begin
               count_d = count_q + CNT_WIDTH'(1);
            end else begin
               count_d = '0;
               if (state_q == ST_UP) begin
                  if (pos_q != LAST_POS) begin
                     pos_d = pos_q + IDX_WIDTH'(1);
                  end else begin
                     case (mode_q)
                        MODE_SINGLE: begin
                           state_d = ST_IDLE;
                           pos_d   = '0;
                           done_d  = 1'b1;
                        end
                        MODE_LOOP: begin
                           pos_d  = '0;
                           done_d = 1'b1;
                        end
                        default: begin
                           state_d = ST_DOWN;
                           pos_d   = TURN_POS;
                        end
                     endcase
                  end
               end else begin
                  if (pos_q != '0) begin
                     pos_d  = pos_q - IDX_WIDTH'(1);
                     done_d = (pos_q == IDX_WIDTH'(1));
                  end else begin
                     state_d = ST_UP;
                     pos_d   = IDX_WIDTH'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            pos_d   = '0;
         end
      endcase

      led_d = (state_d == ST_IDLE) ? '0 : (LED_WIDTH'(1) << pos_d);
   end

   assign POS_OUT   = pos_q;
   assign STATE_OUT = state_q;

endmodule

// File: tb/tb_led_sequencer_multi.sv
// Directed bench for led_sequencer_multi with 4 LEDs and a 4-cycle dwell.
module tb_led_sequencer_multi;

   localparam int unsigned LW = 4;
   localparam int unsigned ST = 4;
   localparam int unsigned CW = 2;
   localparam int unsigned IW = 2;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b1;
   logic [1:0]    MASTER_CONTROL = 2'd0;
   logic          START = 1'b0;
   logic          PAUSE = 1'b0;
   logic [LW-1:0] LED_OUT;
   logic [IW-1:0] POS_OUT;
   logic [1:0]    STATE_OUT;
   logic          SWEEP_DONE;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned seq_up  [4] = '{1, 2, 4, 8};
   int unsigned seq_bl  [8] = '{1, 2, 4, 8, 4, 2, 1, 2};
   int unsigned seq_bp  [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

   led_sequencer_multi #(
      .LED_WIDTH (LW),
      .STEP_TICKS(ST),
      .CNT_WIDTH (CW),
      .IDX_WIDTH (IW)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .MASTER_CONTROL(MASTER_CONTROL),
      .START         (START),
      .PAUSE         (PAUSE),
      .LED_OUT       (LED_OUT),
      .POS_OUT       (POS_OUT),
      .STATE_OUT     (STATE_OUT),
      .SWEEP_DONE    (SWEEP_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_led"},   32'(LED_OUT),    32'd0);
      check({tag, "_state"}, 32'(STATE_OUT),  32'd0);
      check({tag, "_pos"},   32'(POS_OUT),    32'd0);
      check({tag, "_done"},  32'(SWEEP_DONE), 32'd0);
   endtask

   // START sampled at the next edge (edge 0); returns just after it.
   task automatic launch(input logic [1:0] mc);
      MASTER_CONTROL = mc;
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_led, exp_st, exp_done;

      // Asynchronous reset before any clock edge, inputs random
      #1;
      MASTER_CONTROL = 2'($urandom);
      START          = 1'($urandom);
      PAUSE          = 1'($urandom);
      RESET_N        = 1'b0;
      #1;
      check_idle("rst_async");
      repeat (3) step();
      check_idle("rst_held");
      MASTER_CONTROL = 2'd0;
      START = 1'b0;
      PAUSE = 1'b0;
      RESET_N = 1'b1;
      repeat (4) step();
      check_idle("rst_release");

      // START with stop mode is ignored
      launch(2'd0);
      step();
      check_idle("start_stop_ignored");

      // Single sweep
      launch(2'd1);
      for (int e = 1; e <= 18; e++) begin
         exp_led  = (e <= 16) ? 32'(seq_up[(e-1)/4]) : 32'd0;
         exp_st   = (e <= 16) ? 32'd1 : 32'd0;
         exp_done = (e == 17) ? 32'd1 : 32'd0;
         check($sformatf("single_led_e%0d", e),   32'(LED_OUT),    exp_led);
         check($sformatf("single_state_e%0d", e), 32'(STATE_OUT),  exp_st);
         check($sformatf("single_done_e%0d", e),  32'(SWEEP_DONE), exp_done);
         step();
      end

      // Continuous loop, then abort
      launch(2'd2);
      for (int e = 1; e <= 36; e++) begin
         exp_led  = 32'(seq_up[((e-1)/4) % 4]);
         exp_done = (e == 17 || e == 33) ? 32'd1 : 32'd0;
         check($sformatf("loop_led_e%0d", e),   32'(LED_OUT),    exp_led);
         check($sformatf("loop_state_e%0d", e), 32'(STATE_OUT),  32'd1);
         check($sformatf("loop_done_e%0d", e),  32'(SWEEP_DONE), exp_done);
         if (e == 36) MASTER_CONTROL = 2'd0;
         step();
      end
      check_idle("loop_abort");

      // Bounce, then abort
      launch(2'd3);
      for (int e = 1; e <= 32; e++) begin
         exp_st   = (e >= 17 && e <= 28) ? 32'd2 : 32'd1;
         exp_done = (e == 25) ? 32'd1 : 32'd0;
         check($sformatf("bounce_led_e%0d", e),   32'(LED_OUT),    32'(seq_bl[(e-1)/4]));
         check($sformatf("bounce_pos_e%0d", e),   32'(POS_OUT),    32'(seq_bp[(e-1)/4]));
         check($sformatf("bounce_state_e%0d", e), 32'(STATE_OUT),  exp_st);
         check($sformatf("bounce_done_e%0d", e),  32'(SWEEP_DONE), exp_done);
         if (e == 32) MASTER_CONTROL = 2'd0;
         step();
      end
      check_idle("bounce_abort");

      // Loop with pause, ignored START and mode change, abort at edge 20
      launch(2'd2);
      for (int e = 1; e <= 21; e++) begin
         if (e <= 4)       exp_led = 32'd1;
         else if (e <= 11) exp_led = 32'd2;
         else if (e <= 15) exp_led = 32'd4;
         else if (e <= 19) exp_led = 32'd8;
         else if (e == 20) exp_led = 32'd1;
         else              exp_led = 32'd0;
         exp_st   = (e <= 20) ? 32'd1 : 32'd0;
         exp_done = (e == 20) ? 32'd1 : 32'd0;
         check($sformatf("pause_led_e%0d", e),   32'(LED_OUT),    exp_led);
         check($sformatf("pause_state_e%0d", e), 32'(STATE_OUT),  exp_st);
         check($sformatf("pause_done_e%0d", e),  32'(SWEEP_DONE), exp_done);
         PAUSE = (e >= 6 && e <= 8);
         START = (e == 13);
         MASTER_CONTROL = (e >= 20) ? 2'd0 : ((e >= 14) ? 2'd3 : 2'd2);
         step();
      end
      START = 1'b0;
      PAUSE = 1'b0;
      check_idle("pause_after_abort");

      // Abort coinciding with the final dwell end of a single sweep
      launch(2'd1);
      for (int e = 1; e <= 17; e++) begin
         exp_led  = (e <= 16) ? 32'(seq_up[(e-1)/4]) : 32'd0;
         exp_st   = (e <= 16) ? 32'd1 : 32'd0;
         check($sformatf("finabort_led_e%0d", e),   32'(LED_OUT),    exp_led);
         check($sformatf("finabort_state_e%0d", e), 32'(STATE_OUT),  exp_st);
         check($sformatf("finabort_done_e%0d", e),  32'(SWEEP_DONE), 32'd0);
         MASTER_CONTROL = (e == 16) ? 2'd0 : 2'd1;
         step();
      end

      // Asynchronous reset mid-run, then clean restart
      launch(2'd2);
      for (int e = 1; e <= 10; e++) begin
         check($sformatf("arst_led_e%0d", e), 32'(LED_OUT), 32'(seq_up[(e-1)/4]));
         step();
      end
      check("arst_led_before", 32'(LED_OUT), 32'd4);
      RESET_N = 1'b0;
      #1;
      check_idle("arst_mid");
      #2;
      RESET_N = 1'b1;
      launch(2'd2);
      for (int e = 1; e <= 6; e++) begin
         check($sformatf("restart_led_e%0d", e),   32'(LED_OUT),   32'(seq_up[(e-1)/4]));
         check($sformatf("restart_state_e%0d", e), 32'(STATE_OUT), 32'd1);
         step();
      end
      MASTER_CONTROL = 2'd0;
      step();
      check_idle("restart_abort");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
